// File: rtl/decode.sv
// ----------------------------------------------------------------------------
// decode -- RV32I decode stage.
//
// Takes the fetch stage's registered instruction, reads the 32x32 integer
// register file (owned here, with a write-through bypass from writeback),
// builds the sign-extended immediate and control bits, and registers the
// result into the decode->execute pipeline register.
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   pcD, instrD, validD  instruction from fetch (validD=0 is a bubble)
//   stallD               hold the decode->execute register
//   flushE               load a bubble into the decode->execute register
//   wbEnW, wbRdW, wbDataW  register file write port from writeback
//   *E                   registered decode results for execute
// ----------------------------------------------------------------------------
module decode #(
  parameter int REGS_POWER = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcD,
  input  logic [31:0] instrD,
  input  logic        validD,
  input  logic        stallD,
  input  logic        flushE,
  input  logic        wbEnW,
  input  logic [4:0]  wbRdW,
  input  logic [31:0] wbDataW,
  output logic [31:0] pcE,
  output logic [31:0] rs1ValE,
  output logic [31:0] rs2ValE,
  output logic [31:0] immE,
  output logic [4:0]  rs1E,
  output logic [4:0]  rs2E,
  output logic [4:0]  rdE,
  output logic [6:0]  opE,
  output logic [2:0]  funct3E,
  output logic        funct7bE,
  output logic        regWriteE,
  output logic        memReadE,
  output logic        memWriteE,
  output logic        branchE,
  output logic        jumpE,
  output logic        aluSrcE,
  output logic        illegalE,
  output logic        validE
);

  localparam int NREGS = 1 << REGS_POWER;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src;
    logic        illegal;
    logic        vld;
  } ex_t;

  logic [31:0] rf [NREGS];

  logic [4:0]  rs1_p0, rs2_p0, rd_p0;
  logic [6:0]  op_p0;
  logic [31:0] rs1_val_p0, rs2_val_p0;
  ex_t         dec_p0;
  ex_t         ex_p1;

  assign rs1_p0 = instrD[19:15];
  assign rs2_p0 = instrD[24:20];
  assign rd_p0  = instrD[11:7];
  assign op_p0  = instrD[6:0];

  // Register file write port; x0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wbEnW && (wbRdW != 5'd0)) begin
      rf[wbRdW[REGS_POWER-1:0]] <= wbDataW;
    end
  end

  // Read ports: x0 forced to zero, same-cycle writeback bypassed through so
  // decode never sees a stale value for the instruction retiring this cycle.
  always_comb begin
    rs1_val_p0 = rf[rs1_p0[REGS_POWER-1:0]];
    rs2_val_p0 = rf[rs2_p0[REGS_POWER-1:0]];
    if (wbEnW && (wbRdW != 5'd0) && (wbRdW == rs1_p0)) rs1_val_p0 = wbDataW;
    if (wbEnW && (wbRdW != 5'd0) && (wbRdW == rs2_p0)) rs2_val_p0 = wbDataW;
    if (rs1_p0 == 5'd0) rs1_val_p0 = '0;
    if (rs2_p0 == 5'd0) rs2_val_p0 = '0;
  end

  // Stage p0: immediate and control decode.
  always_comb begin
    dec_p0         = '0;
    dec_p0.pc      = pcD;
    dec_p0.rs1_val = rs1_val_p0;
    dec_p0.rs2_val = rs2_val_p0;
    dec_p0.rs1     = rs1_p0;
    dec_p0.rs2     = rs2_p0;
    dec_p0.rd      = rd_p0;
    dec_p0.op      = op_p0;
    dec_p0.funct3  = instrD[14:12];
    dec_p0.funct7b = instrD[30];
    dec_p0.vld     = 1'b1;
    case (op_p0)
      OP_LUI, OP_AUIPC: begin
        dec_p0.imm       = {instrD[31:12], 12'b0};
        dec_p0.reg_write = 1'b1;
        dec_p0.alu_src   = 1'b1;
      end
      OP_JAL: begin
        dec_p0.imm       = {{12{instrD[31]}}, instrD[19:12], instrD[20],
                            instrD[30:21], 1'b0};
        dec_p0.reg_write = 1'b1;
        dec_p0.jump      = 1'b1;
        dec_p0.alu_src   = 1'b1;
      end
      OP_JALR: begin
        dec_p0.imm       = {{20{instrD[31]}}, instrD[31:20]};
        dec_p0.reg_write = 1'b1;
        dec_p0.jump      = 1'b1;
        dec_p0.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        dec_p0.imm    = {{20{instrD[31]}}, instrD[7], instrD[30:25],
                         instrD[11:8], 1'b0};
        dec_p0.branch = 1'b1;
      end
      OP_LOAD: begin
        dec_p0.imm       = {{20{instrD[31]}}, instrD[31:20]};
        dec_p0.reg_write = 1'b1;
        dec_p0.mem_read  = 1'b1;
        dec_p0.alu_src   = 1'b1;
      end
      OP_STORE: begin
        dec_p0.imm       = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
        dec_p0.mem_write = 1'b1;
        dec_p0.alu_src   = 1'b1;
      end
      OP_IMM: begin
        dec_p0.imm       = {{20{instrD[31]}}, instrD[31:20]};
        dec_p0.reg_write = 1'b1;
        dec_p0.alu_src   = 1'b1;
      end
      OP_OP: begin
        dec_p0.reg_write = 1'b1;
      end
      default: begin
        dec_p0.illegal = 1'b1;
      end
    endcase
    // Writes to x0 are architecturally dropped, so don't request them.
    if (rd_p0 == 5'd0) dec_p0.reg_write = 1'b0;
    if (!validD) dec_p0 = '0;
  end

  // Stage p1: decode->execute register (flush beats stall beats load).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_p1 <= '0;
    end else if (flushE) begin
      ex_p1 <= '0;
    end else if (!stallD) begin
      ex_p1 <= dec_p0;
    end
  end

  assign pcE       = ex_p1.pc;
  assign rs1ValE   = ex_p1.rs1_val;
  assign rs2ValE   = ex_p1.rs2_val;
  assign immE      = ex_p1.imm;
  assign rs1E      = ex_p1.rs1;
  assign rs2E      = ex_p1.rs2;
  assign rdE       = ex_p1.rd;
  assign opE       = ex_p1.op;
  assign funct3E   = ex_p1.funct3;
  assign funct7bE  = ex_p1.funct7b;
  assign regWriteE = ex_p1.reg_write;
  assign memReadE  = ex_p1.mem_read;
  assign memWriteE = ex_p1.mem_write;
  assign branchE   = ex_p1.branch;
  assign jumpE     = ex_p1.jump;
  assign aluSrcE   = ex_p1.alu_src;
  assign illegalE  = ex_p1.illegal;
  assign validE    = ex_p1.vld;

endmodule

// File: tb/tb_decode.sv
// ----------------------------------------------------------------------------
// tb_decode -- self-checking bench for decode: directed cases followed by
// randomized instruction / writeback / stall / flush traffic, all compared
// against a behavioural model of the decode stage kept in this file.
// ----------------------------------------------------------------------------
module tb_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pcD = '0, instrD = '0, wbDataW = '0;
  logic        validD = 1'b0, stallD = 1'b0, flushE = 1'b0, wbEnW = 1'b0;
  logic [4:0]  wbRdW = '0;
  logic [31:0] pcE, rs1ValE, rs2ValE, immE;
  logic [4:0]  rs1E, rs2E, rdE;
  logic [6:0]  opE;
  logic [2:0]  funct3E;
  logic        funct7bE, regWriteE, memReadE, memWriteE, branchE, jumpE;
  logic        aluSrcE, illegalE, validE;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b, rw, mr, mw, br, jmp, asrc, ill, vld;
  } mdl_t;

  mdl_t        mdl;
  logic [31:0] mrf [32];

  decode #(.REGS_POWER(5)) dut (
    .clk(clk), .reset(reset), .pcD(pcD), .instrD(instrD), .validD(validD),
    .stallD(stallD), .flushE(flushE), .wbEnW(wbEnW), .wbRdW(wbRdW),
    .wbDataW(wbDataW), .pcE(pcE), .rs1ValE(rs1ValE), .rs2ValE(rs2ValE),
    .immE(immE), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .opE(opE),
    .funct3E(funct3E), .funct7bE(funct7bE), .regWriteE(regWriteE),
    .memReadE(memReadE), .memWriteE(memWriteE), .branchE(branchE),
    .jumpE(jumpE), .aluSrcE(aluSrcE), .illegalE(illegalE), .validE(validE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic mdl_t zero_mdl();
    mdl_t z;
    z.pc = 0; z.rs1v = 0; z.rs2v = 0; z.imm = 0; z.rs1 = 0; z.rs2 = 0;
    z.rd = 0; z.op = 0; z.f3 = 0; z.f7b = 0; z.rw = 0; z.mr = 0; z.mw = 0;
    z.br = 0; z.jmp = 0; z.asrc = 0; z.ill = 0; z.vld = 0;
    return z;
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    if (idx == 0) return 32'd0;
    if (wbEnW && wbRdW != 0 && int'(wbRdW) == idx) return wbDataW;
    return mrf[idx];
  endfunction

  // Field extraction done numerically: gather the immediate bits as an
  // unsigned integer and subtract 2^n when the sign bit is set.
  function automatic mdl_t model_decode();
    mdl_t d = zero_mdl();
    int   imm = 0;
    logic [31:0] w = instrD;
    if (!validD) return d;
    d.vld = 1; d.pc = pcD;
    d.op  = 7'(w % 128);
    d.rd  = 5'((w >> 7) % 32);
    d.f3  = 3'((w >> 12) % 8);
    d.rs1 = 5'((w >> 15) % 32);
    d.rs2 = 5'((w >> 20) % 32);
    d.f7b = 1'((w >> 30) % 2);
    d.rs1v = model_read(int'(d.rs1));
    d.rs2v = model_read(int'(d.rs2));
    case (int'(d.op))
      'h03, 'h13, 'h67: begin
        imm = int'(w >> 20);
        if (imm >= 2048) imm -= 4096;
      end
      'h23: begin
        imm = int'((w >> 25) * 32 + (w >> 7) % 32);
        if (imm >= 2048) imm -= 4096;
      end
      'h63: begin
        imm = int'((w >> 31) * 4096 + ((w >> 7) % 2) * 2048 +
                   ((w >> 25) % 64) * 32 + ((w >> 8) % 16) * 2);
        if (imm >= 4096) imm -= 8192;
      end
      'h37, 'h17: imm = int'(w & 32'hFFFF_F000);
      'h6F: begin
        imm = int'((w >> 31) * (1 << 20) + ((w >> 12) % 256) * 4096 +
                   ((w >> 20) % 2) * 2048 + ((w >> 21) % 1024) * 2);
        if (imm >= (1 << 20)) imm -= (1 << 21);
      end
      default: imm = 0;
    endcase
    d.imm = imm;
    case (int'(d.op))
      'h37, 'h17, 'h13: begin d.rw = 1; d.asrc = 1; end
      'h6F, 'h67: begin d.rw = 1; d.asrc = 1; d.jmp = 1; end
      'h03: begin d.rw = 1; d.asrc = 1; d.mr = 1; end
      'h23: begin d.asrc = 1; d.mw = 1; end
      'h63: d.br = 1;
      'h33: d.rw = 1;
      default: d.ill = 1;
    endcase
    if (d.rd == 0) d.rw = 0;
    return d;
  endfunction

  task automatic check_all();
    check("pcE", pcE, mdl.pc);
    check("rs1ValE", rs1ValE, mdl.rs1v);
    check("rs2ValE", rs2ValE, mdl.rs2v);
    check("immE", immE, mdl.imm);
    check("rs1E", 32'(rs1E), 32'(mdl.rs1));
    check("rs2E", 32'(rs2E), 32'(mdl.rs2));
    check("rdE", 32'(rdE), 32'(mdl.rd));
    check("opE", 32'(opE), 32'(mdl.op));
    check("funct3E", 32'(funct3E), 32'(mdl.f3));
    check("funct7bE", 32'(funct7bE), 32'(mdl.f7b));
    check("regWriteE", 32'(regWriteE), 32'(mdl.rw));
    check("memReadE", 32'(memReadE), 32'(mdl.mr));
    check("memWriteE", 32'(memWriteE), 32'(mdl.mw));
    check("branchE", 32'(branchE), 32'(mdl.br));
    check("jumpE", 32'(jumpE), 32'(mdl.jmp));
    check("aluSrcE", 32'(aluSrcE), 32'(mdl.asrc));
    check("illegalE", 32'(illegalE), 32'(mdl.ill));
    check("validE", 32'(validE), 32'(mdl.vld));
  endtask

  // Advance one clock: update the model from the inputs as they stand, then
  // compare after the edge.
  task automatic step();
    mdl_t nxt = model_decode();
    if (flushE) mdl = zero_mdl();
    else if (!stallD) mdl = nxt;
    if (wbEnW && wbRdW != 0) mrf[wbRdW] = wbDataW;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic st,
                       input logic fl, input logic we, input logic [4:0] wrd,
                       input logic [31:0] wd);
    pcD = pcD + 4; instrD = ins; validD = v; stallD = st; flushE = fl;
    wbEnW = we; wbRdW = wrd; wbDataW = wd;
  endtask

  task automatic model_reset();
    mdl = zero_mdl();
    for (int i = 0; i < 32; i++) mrf[i] = 0;
  endtask

  initial begin
    logic [6:0] ops [10];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // ADDI x1, x0, 5
    drive(32'h0050_0093, 1, 0, 0, 0, 0, 0);
    step();
    check("addi_rd", 32'(rdE), 1);
    check("addi_imm", immE, 32'h5);
    check("addi_op", 32'(opE), 32'h13);
    check("addi_rw", 32'(regWriteE), 1);
    check("addi_asrc", 32'(aluSrcE), 1);

    // ADD x3, x2, x2 with same-cycle writeback to x2
    drive(32'h0021_01B3, 1, 0, 0, 1, 5'd2, 32'hDEAD_BEEF);
    step();
    check("byp_rs1", rs1ValE, 32'hDEAD_BEEF);
    check("byp_rs2", rs2ValE, 32'hDEAD_BEEF);
    check("byp_rd", 32'(rdE), 3);
    drive(32'h0001_01B3, 1, 0, 0, 0, 0, 0);
    step();
    check("x2_after", rs1ValE, 32'hDEAD_BEEF);

    // Write to x0 is dropped
    drive(32'h0000_01B3, 1, 0, 0, 1, 5'd0, 32'h1234);
    step();
    check("x0_byp", rs1ValE, 0);
    drive(32'h0000_01B3, 1, 0, 0, 0, 0, 0);
    step();
    check("x0_read", rs1ValE, 0);

    drive(32'hFE00_0CE3, 1, 0, 0, 0, 0, 0);
    step();
    check("beq_imm", immE, 32'hFFFF_FFF8);
    check("beq_br", 32'(branchE), 1);
    check("beq_asrc", 32'(aluSrcE), 0);
    drive(32'h1234_50B7, 1, 0, 0, 0, 0, 0);
    step();
    check("lui_imm", immE, 32'h1234_5000);
    drive(32'h0000_007F, 1, 0, 0, 0, 0, 0);
    step();
    check("ill_flag", 32'(illegalE), 1);
    check("ill_rw", 32'(regWriteE), 0);

    // Stall holds, flush beats stall, invalid is a bubble
    drive(32'h0050_0093, 1, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive($urandom, 1, 1, 0, 1, 5'd1, $urandom);
      step();
      check("stall_imm", immE, 32'h5);
      check("stall_rd", 32'(rdE), 1);
    end
    drive(32'h0050_0093, 1, 1, 1, 0, 0, 0);
    step();
    check("flush_vld", 32'(validE), 0);
    check("flush_rw", 32'(regWriteE), 0);
    drive(32'h0050_0093, 0, 0, 0, 0, 0, 0);
    step();
    check("bubble_vld", 32'(validE), 0);
    check("bubble_imm", immE, 0);

    // Asynchronous reset mid-cycle
    drive(32'h0050_0093, 1, 0, 0, 1, 5'd7, 32'h55AA_55AA);
    step();
    check("pre_rst_vld", 32'(validE), 1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    #3 reset = 1'b1;
    for (int i = 1; i < 32; i++) begin
      drive((32'(i) << 20) | (32'(i) << 15) | 32'h33, 1, 0, 0, 0, 0, 0);
      step();
      check("rf_clear", rs1ValE, 0);
    end

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      logic [31:0] w = $urandom;
      logic [4:0]  wrd;
      w[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 15) == 0) w = $urandom;
      wrd = ($urandom_range(0, 2) == 0) ? w[19:15] : 5'($urandom_range(0, 31));
      drive(w, $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, wrd, $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
